aes_byte_host: RTL and testbench



---
 rtl/aes_byte_host.sv | 211 +++++++++++++++++++++
 tb/tb_aes_byte_host.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_host.sv
// aes_byte_host: host-side initiator for the byte-serial AES-128 core.
//   Takes a 128-bit key/plaintext pair on a valid/ready input, releases the
//   core's active-high reset, streams 16 key/data byte pairs MSB-first,
//   collects 16 ciphertext bytes under enc_valid (gaps allowed) and returns
//   the ciphertext on a valid/ready output.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_key/in_pt  input block handshake (byte 0 = [127:120])
//   out_valid/out_ready/out_ct    ciphertext handshake (first byte in [127:120])
//   busy                          high in every state except IDLE
//   timeout                       one-cycle pulse on watchdog abort
//   enc_rst/enc_key/enc_din       drive to the core
//   enc_dout/enc_valid            ciphertext byte stream from the core
// Optional feature: define AES_TIMEOUT_EN to enable a 12-bit watchdog over
//   WAIT/CAPTURE that aborts after TIMEOUT_CYCLES cycles.
module aes_byte_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         busy,
  output logic         timeout,
  output logic         enc_rst,
  output logic [7:0]   enc_key,
  output logic [7:0]   enc_din,
  input  logic [7:0]   enc_dout,
  input  logic         enc_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t       r_state,     w_state_nx;
  logic [4:0]   r_cnt,       w_cnt_nx;
  logic [127:0] r_key,       w_key_nx;
  logic [127:0] r_pt,        w_pt_nx;
  logic [127:0] r_ct,        w_ct_nx;
  logic         r_in_ready,  w_in_ready_nx;
  logic         r_out_valid, w_out_valid_nx;
  logic         r_busy,      w_busy_nx;
  logic         r_enc_rst,   w_enc_rst_nx;
  logic [7:0]   r_enc_key,   w_enc_key_nx;
  logic [7:0]   r_enc_din,   w_enc_din_nx;

  // Index of the byte to present on the next LOAD cycle.
  logic [3:0]   w_nidx;
  logic [6:0]   w_rsh;
  logic [4:0]   w_cnt_inc;

  assign w_cnt_inc = r_cnt + 5'd1;
  assign w_nidx    = w_cnt_inc[3:0];
  assign w_rsh     = {4'd15 - w_nidx, 3'b000};

`ifdef AES_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYCLES - 1);
  logic [11:0] r_wdog, w_wdog_nx;
  logic        r_timeout, w_timeout_nx;
  assign timeout = r_timeout;
`else
  logic [11:0] w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = 12'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_key_nx       = r_key;
    w_pt_nx        = r_pt;
    w_ct_nx        = r_ct;
    w_in_ready_nx  = r_in_ready;
    w_out_valid_nx = r_out_valid;
    w_busy_nx      = r_busy;
    w_enc_rst_nx   = r_enc_rst;
    w_enc_key_nx   = r_enc_key;
    w_enc_din_nx   = r_enc_din;
`ifdef AES_TIMEOUT_EN
    w_wdog_nx      = r_wdog;
    w_timeout_nx   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_key_nx      = in_key;
          w_pt_nx       = in_pt;
          w_cnt_nx      = '0;
          w_state_nx    = S_LOAD;
          w_in_ready_nx = 1'b0;
          w_busy_nx     = 1'b1;
          w_enc_rst_nx  = 1'b0;
          // Byte 0 comes straight from the inputs so it is on the bus in
          // the same cycle the core first sees its reset released.
          w_enc_key_nx  = in_key[127:120];
          w_enc_din_nx  = in_pt[127:120];
        end
      end
      S_LOAD: begin
        if (r_cnt == 5'd15) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = '0;
`ifdef AES_TIMEOUT_EN
          w_wdog_nx  = '0;
`endif
        end else begin
          w_cnt_nx     = w_cnt_inc;
          w_enc_key_nx = 8'(r_key >> w_rsh);
          w_enc_din_nx = 8'(r_pt >> w_rsh);
        end
      end
      S_WAIT: begin
        if (enc_valid) begin
          w_ct_nx    = {r_ct[119:0], enc_dout};
          w_cnt_nx   = 5'd1;
          w_state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (enc_valid) begin
          w_ct_nx  = {r_ct[119:0], enc_dout};
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == 5'd16) begin
            w_state_nx     = S_DONE;
            w_out_valid_nx = 1'b1;
            w_enc_rst_nx   = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nx = 1'b0;
          w_state_nx     = S_IDLE;
          w_in_ready_nx  = 1'b1;
          w_busy_nx      = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
`ifdef AES_TIMEOUT_EN
    // A block completing on the same cycle the watchdog expires wins.
    if ((r_state == S_WAIT || r_state == S_CAPTURE) && w_state_nx != S_DONE) begin
      if (r_wdog == TO_LAST) begin
        w_state_nx    = S_IDLE;
        w_cnt_nx      = '0;
        w_timeout_nx  = 1'b1;
        w_enc_rst_nx  = 1'b1;
        w_in_ready_nx = 1'b1;
        w_busy_nx     = 1'b0;
      end else begin
        w_wdog_nx = r_wdog + 12'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_key       <= '0;
      r_pt        <= '0;
      r_ct        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_enc_rst   <= 1'b1;
      r_enc_key   <= '0;
      r_enc_din   <= '0;
`ifdef AES_TIMEOUT_EN
      r_wdog      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_key       <= w_key_nx;
      r_pt        <= w_pt_nx;
      r_ct        <= w_ct_nx;
      r_in_ready  <= w_in_ready_nx;
      r_out_valid <= w_out_valid_nx;
      r_busy      <= w_busy_nx;
      r_enc_rst   <= w_enc_rst_nx;
      r_enc_key   <= w_enc_key_nx;
      r_enc_din   <= w_enc_din_nx;
`ifdef AES_TIMEOUT_EN
      r_wdog      <= w_wdog_nx;
      r_timeout   <= w_timeout_nx;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ct    = r_ct;
  assign busy      = r_busy;
  assign enc_rst   = r_enc_rst;
  assign enc_key   = r_enc_key;
  assign enc_din   = r_enc_din;

endmodule

// File: tb/tb_aes_byte_host.sv
// Testbench for aes_byte_host. The bench plays the core: it emits a chosen
// 128-bit ciphertext one byte at a time (first byte = most significant) with
// configurable latency and gaps, and checks the byte stream presented to the
// core and the reassembled ciphertext against the block it chose.
module tb_aes_byte_host;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = '0;
  logic [127:0] in_pt = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ct;
  logic         busy;
  logic         timeout;
  logic         enc_rst;
  logic [7:0]   enc_key;
  logic [7:0]   enc_din;
  logic [7:0]   enc_dout = '0;
  logic         enc_valid = 1'b0;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  aes_byte_host #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_pt(in_pt),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
    .busy(busy), .timeout(timeout),
    .enc_rst(enc_rst), .enc_key(enc_key), .enc_din(enc_din),
    .enc_dout(enc_dout), .enc_valid(enc_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Byte n of a block, byte 0 being the most significant.
  function automatic logic [7:0] byte_of(input logic [127:0] w, input int n);
    return 8'(w >> (8 * (15 - n)));
  endfunction

  task automatic check_rst_vals(input string tag);
    check({tag, "_ctl"}, 128'({in_ready, out_valid, busy, timeout, enc_rst}), 128'(5'b10001));
    check({tag, "_bytes"}, 128'({enc_key, enc_din}), '0);
    check({tag, "_ct"}, out_ct, '0);
  endtask

  // Called just after a falling edge; reset is checked before the next rise.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0; enc_valid = 1'b0; out_ready = 1'b0;
    #1 check_rst_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // lat: idle cycles in WAIT before byte 0; gap: idle cycles before each later
  // byte (negative = random 0..3); hold: DONE cycles with out_ready low;
  // abort_load/abort_cap: byte index at which to reset (-1 = never).
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct, input int unsigned lat,
                           input int gap, input int unsigned hold,
                           input int abort_load, input int abort_cap, input bit to_mode);
    int unsigned w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 128'(in_ready), 128'(1'b1));
    in_valid = 1'b1; in_key = key; in_pt = pt;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("load_byte", 128'({enc_rst, enc_key, enc_din, in_ready, busy, out_valid}),
            128'({1'b0, byte_of(key, i), byte_of(pt, i), 1'b0, 1'b1, 1'b0}));
      if (i == abort_load) begin
        do_reset();
        return;
      end
      // Junk on ignored inputs while loading.
      in_valid = 1'($urandom); in_key = rnd128(); in_pt = rnd128();
      enc_valid = 1'($urandom); enc_dout = 8'($urandom); out_ready = 1'($urandom);
    end
`ifdef AES_TIMEOUT_EN
    if (to_mode) begin
      for (int k = 0; k <= 110; k++) begin
        @(negedge clk);
        check("watchdog", 128'({timeout, enc_rst, in_ready, out_valid}),
              128'((k < 100) ? 4'b0000 : ((k == 100) ? 4'b1110 : 4'b0110)));
        in_valid = 1'b0; enc_valid = 1'b0; out_ready = 1'($urandom);
      end
      out_ready = 1'b0;
      return;
    end
`else
    check("to_mode_unused", 128'(to_mode), 128'(1'b0));
`endif
    for (int i = 0; i < 16; i++) begin
      int unsigned g;
      g = (i == 0) ? lat : ((gap >= 0) ? int'(gap) : $urandom_range(0, 3));
      for (int unsigned s = 0; s <= g; s++) begin
        @(negedge clk);
        check("stream_ctl", 128'({out_valid, in_ready, busy, enc_rst, timeout}), 128'(5'b00100));
        if (i == abort_cap && s == 0) begin
          do_reset();
          return;
        end
        enc_valid = (s == g);
        enc_dout  = (s == g) ? byte_of(ct, i) : 8'($urandom);
        in_valid = 1'($urandom); in_key = rnd128(); in_pt = rnd128();
        out_ready = 1'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; enc_valid = 1'b0; out_ready = 1'b0;
    check("done_ctl", 128'({out_valid, in_ready, busy, enc_rst}), 128'(4'b1011));
    check("done_ct", out_ct, ct);
    for (int unsigned h = 0; h < hold; h++) begin
      enc_valid = 1'($urandom); enc_dout = 8'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      check("hold_ctl", 128'({out_valid, in_ready, busy, enc_rst}), 128'(4'b1011));
      check("hold_ct", out_ct, ct);
    end
    in_valid = 1'b0; enc_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_ctl", 128'({out_valid, in_ready, busy, enc_rst}), 128'(4'b0101));
    check("release_ct", out_ct, ct);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_rst_vals("reset");
    rst_n = 1'b1;

    // FIPS-197 appendix B vector; the bench emits the known ciphertext.
    run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 3, 0, 2, -1, -1, 1'b0);

    // One idle cycle between every ciphertext byte.
    run_block(rnd128(), rnd128(), 128'h000102030405060708090a0b0c0d0e0f, 1, 1, 0, -1, -1, 1'b0);

    // Long backpressure, then an immediate second block.
    run_block(rnd128(), rnd128(), rnd128(), 2, -1, 50, -1, -1, 1'b0);
    run_block(rnd128(), rnd128(), rnd128(), 0, 0, 0, -1, -1, 1'b0);

    // Reset while byte 7 is on the bus, then a clean block.
    run_block(rnd128(), rnd128(), rnd128(), 0, 0, 0, 7, -1, 1'b0);
    run_block(rnd128(), rnd128(), rnd128(), 4, -1, 1, -1, -1, 1'b0);

    // Reset after 5 bytes captured: partial ciphertext must be discarded.
    run_block(rnd128(), rnd128(), rnd128(), 2, -1, 0, -1, 5, 1'b0);
    run_block(rnd128(), rnd128(), rnd128(), 0, -1, 0, -1, -1, 1'b0);

    for (int n = 0; n < 6; n++)
      run_block(rnd128(), rnd128(), rnd128(), $urandom_range(0, 6), -1,
                $urandom_range(0, 3), -1, -1, 1'b0);

`ifdef AES_TIMEOUT_EN
    run_block(rnd128(), rnd128(), rnd128(), 0, 0, 0, -1, -1, 1'b1);
    run_block(rnd128(), rnd128(), rnd128(), 5, -1, 0, -1, -1, 1'b0);
`else
    // Without the watchdog a long WAIT must simply be waited out.
    run_block(rnd128(), rnd128(), rnd128(), 150, 0, 0, -1, -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
